// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch queue stage.
//   DEF_*          default parameter values for fetch_queue_stage
//   fetch_entry_t  {pc, instruction} record as buffered toward decode
//   sat_add32      32-bit saturating add used by the optional perf counters
package fetch_pkg;

  localparam int unsigned         DEF_INSTR_W  = 33;
  localparam int unsigned         DEF_PC_W     = 33;
  localparam logic [DEF_PC_W-1:0] DEF_RESET_PC = '0;
  localparam int unsigned         DEF_PC_STEP  = 4;
  localparam int unsigned         DEF_DEPTH    = 4;

  typedef struct packed {
    logic [DEF_PC_W-1:0]    pc;
    logic [DEF_INSTR_W-1:0] instruction;
  } fetch_entry_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] inc);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, inc};
    return sum[32] ? '1 : sum[31:0];
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Circular-buffer FIFO with wrapping pointers, occupancy count and synchronous flush.
// The head entry is read straight out of the storage registers, so a written entry
// is visible on head the cycle after it is pushed.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (storage, pointers, count cleared)
//   flush      empty the FIFO; overrides push and pop
//   push       write push_data (ignored when full and not popping)
//   push_data  entry to write
//   pop        drop the head entry (ignored when empty)
//   head       oldest entry
//   count      number of valid entries, 0..DEPTH
module fetch_queue_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop  = pop && !flush && (count_q != '0);
    // Full is fine as long as the head leaves in the same cycle.
    do_push = push && !flush && ((count_q != CNT_W'(DEPTH)) || do_pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage: owns the fetch PC, issues in-order requests to instruction
// memory, buffers {pc, instruction} pairs in a DEPTH-entry queue and hands them to
// decode over valid/ready. A redirect flushes the queue and drops in-flight responses.
// Optional feature: define FETCH_PERF_CNT_EN to add 32-bit saturating perf counters.
// Ports:
//   clk, reset                       clock (rising edge), async active-low reset
//   hold                             stall issue and dequeue (responses still land)
//   redirect_valid, redirect_pc      branch/jump redirect, highest priority
//   imem_req_valid/ready, imem_addr  request channel to instruction memory
//   imem_rsp_valid, imem_rsp_data    in-order response channel, no backpressure
//   out_valid/ready, out_instruction, out_pc   head entry toward decode
//   perf_fetched/flushed/stall       (FETCH_PERF_CNT_EN only) dequeues, discarded
//                                    entries plus dropped responses, idle-output cycles
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter int unsigned     INSTR_W  = DEF_INSTR_W,
  parameter int unsigned     PC_W     = DEF_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC),
  parameter int unsigned     PC_STEP  = DEF_PC_STEP,
  parameter int unsigned     DEPTH    = DEF_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hold,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instruction,
  output logic [PC_W-1:0]    out_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushed,
  output logic [31:0]        perf_stall
`endif
);

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = PC_W + INSTR_W;

  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]   q_count;
  logic [CNT_W-1:0]   outstanding;
  logic [CNT_W:0]     credit_used;
  logic [ENTRY_W-1:0] q_head;
  logic [PC_W-1:0]    pcq_head;
  logic               req_accept;
  logic               rsp_drop;
  logic               rsp_keep;
  logic               deq;

  // Issue credit covers both queued entries and live requests, so every kept
  // response is guaranteed a queue slot. Reset gates the valid so nothing is
  // requested while the stage is held in reset.
  always_comb begin
    credit_used    = {1'b0, q_count} + {1'b0, outstanding};
    imem_req_valid = reset && !hold && !redirect_valid &&
                     (credit_used < (CNT_W + 1)'(DEPTH));
    imem_addr      = fetch_pc_q;
    req_accept     = imem_req_valid && imem_req_ready;
  end

  // Responses belonging to requests issued before a redirect are dropped, including
  // one that arrives in the redirect cycle itself.
  always_comb begin
    rsp_drop = imem_rsp_valid && (redirect_valid || (drop_cnt_q != '0));
    rsp_keep = imem_rsp_valid && !rsp_drop;
  end

  always_comb begin
    out_valid = (q_count != '0) && !hold;
    deq       = out_valid && out_ready && !redirect_valid;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (req_accept) begin
      fetch_pc_d = fetch_pc_q + PC_W'(PC_STEP);
    end
  end

  // Every live request becomes a pending drop on redirect; consecutive redirects
  // keep adding to the same counter.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      drop_cnt_d = drop_cnt_q + outstanding - CNT_W'(imem_rsp_valid);
    end else if (rsp_drop) begin
      drop_cnt_d = drop_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // PC FIFO: address of each live request. A redirect empties it, so it only ever
  // tracks requests whose responses will be kept; its occupancy is the outstanding
  // count, and dropped responses never pop it.
  fetch_queue_fifo #(
    .WIDTH(PC_W),
    .DEPTH(DEPTH)
  ) u_pc_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (req_accept),
    .push_data (fetch_pc_q),
    .pop       (rsp_keep),
    .head      (pcq_head),
    .count     (outstanding)
  );

  fetch_queue_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_instr_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data ({pcq_head, imem_rsp_data}),
    .pop       (deq),
    .head      (q_head),
    .count     (q_count)
  );

  assign out_pc          = q_head[ENTRY_W-1 -: PC_W];
  assign out_instruction = q_head[INSTR_W-1:0];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_flushed_q;
  logic [31:0] perf_stall_q;
  logic [31:0] flush_inc;

  always_comb begin
    flush_inc = (redirect_valid ? 32'(q_count) : 32'd0) + 32'(rsp_drop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= sat_add32(perf_fetched_q, 32'(deq));
      perf_flushed_q <= sat_add32(perf_flushed_q, flush_inc);
      perf_stall_q   <= sat_add32(perf_stall_q, 32'(!out_valid));
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: per-cycle vector table against a fixed-latency memory
// model (instruction = ~address), plus hand-written backpressure and async-reset runs.
module tb_fetch_queue_stage;

  logic        clk;
  logic        reset;
  logic        hold;
  logic        redirect_valid;
  logic [32:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [32:0] imem_addr;
  logic        imem_rsp_valid;
  logic [32:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] out_instruction;
  logic [32:0] out_pc;

  fetch_queue_stage dut (
    .clk             (clk),
    .reset           (reset),
    .hold            (hold),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: fixed latency of mem_lat cycles, response data = ~address.
  int          mem_lat = 1;
  logic        pipe_v [4];
  logic [32:0] pipe_a [4];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_a[i] <= '0;
      end
    end else begin
      pipe_v[0] <= imem_req_valid && imem_req_ready;
      pipe_a[0] <= imem_addr;
      for (int i = 1; i < 4; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end
    end
  end

  assign imem_rsp_valid = pipe_v[mem_lat-1];
  assign imem_rsp_data  = ~pipe_a[mem_lat-1];

  typedef struct {
    bit          rst;
    int          lat;
    logic        hold;
    logic        ordy;
    logic        redir;
    logic [32:0] rpc;
    logic        erv;
    logic [32:0] eaddr;
    logic        eov;
    logic [32:0] epc;
  } row_t;

  row_t rows[$];
  int   tests  = 0;
  int   failed = 0;
  int   accepted;

  function automatic void add(input bit rst, input int lat, input logic hd, input logic ordy,
                              input logic redir, input logic [32:0] rpc, input logic erv,
                              input logic [32:0] eaddr, input logic eov,
                              input logic [32:0] epc);
    row_t r;
    r.rst = rst; r.lat = lat; r.hold = hd; r.ordy = ordy; r.redir = redir; r.rpc = rpc;
    r.erv = erv; r.eaddr = eaddr; r.eov = eov; r.epc = epc;
    rows.push_back(r);
  endfunction

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: actual %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int lat);
    @(negedge clk);
    reset          = 1'b0;
    hold           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    imem_req_ready = 1'b1;
    mem_lat        = lat;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset          = 1'b0;
    hold           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    imem_req_ready = 1'b1;

    // rst lat hold ordy redir rpc | req_valid addr out_valid out_pc
    // Streaming, 1-cycle memory: two-cycle fill then one instruction per cycle.
    add(1, 1, 0, 1, 0, 0,  1, 33'h0,   0, 0);
    add(0, 1, 0, 1, 0, 0,  1, 33'h4,   0, 0);
    add(0, 1, 0, 1, 0, 0,  1, 33'h8,   1, 33'h0);
    add(0, 1, 0, 1, 0, 0,  1, 33'hc,   1, 33'h4);
    add(0, 1, 0, 1, 0, 0,  1, 33'h10,  1, 33'h8);
    add(0, 1, 0, 1, 0, 0,  1, 33'h14,  1, 33'hc);
    // Redirect with two requests in flight (3-cycle memory): both dropped.
    add(1, 3, 0, 1, 0, 0,        1, 33'h0,   0, 0);
    add(0, 3, 0, 1, 0, 0,        1, 33'h4,   0, 0);
    add(0, 3, 0, 1, 1, 33'h100,  0, 33'h8,   0, 0);
    add(0, 3, 0, 1, 0, 0,        1, 33'h100, 0, 0);
    add(0, 3, 0, 1, 0, 0,        1, 33'h104, 0, 0);
    add(0, 3, 0, 1, 0, 0,        1, 33'h108, 0, 0);
    add(0, 3, 0, 1, 0, 0,        1, 33'h10c, 0, 0);
    add(0, 3, 0, 1, 0, 0,        0, 33'h110, 1, 33'h100);
    add(0, 3, 0, 1, 0, 0,        1, 33'h110, 1, 33'h104);
    add(0, 3, 0, 1, 0, 0,        1, 33'h114, 1, 33'h108);
    // Redirect in the same cycle as a response (2-cycle memory).
    add(1, 2, 0, 1, 0, 0,        1, 33'h0,   0, 0);
    add(0, 2, 0, 1, 0, 0,        1, 33'h4,   0, 0);
    add(0, 2, 0, 1, 1, 33'h200,  0, 33'h8,   0, 0);
    add(0, 2, 0, 1, 0, 0,        1, 33'h200, 0, 0);
    add(0, 2, 0, 1, 0, 0,        1, 33'h204, 0, 0);
    add(0, 2, 0, 1, 0, 0,        1, 33'h208, 0, 0);
    add(0, 2, 0, 1, 0, 0,        1, 33'h20c, 1, 33'h200);
    add(0, 2, 0, 1, 0, 0,        1, 33'h210, 1, 33'h204);
    // Hold for five cycles while responses land, then in-order release.
    add(1, 2, 0, 1, 0, 0,  1, 33'h0,   0, 0);
    add(0, 2, 0, 1, 0, 0,  1, 33'h4,   0, 0);
    add(0, 2, 0, 1, 0, 0,  1, 33'h8,   0, 0);
    add(0, 2, 1, 1, 0, 0,  0, 33'hc,   0, 0);
    add(0, 2, 1, 1, 0, 0,  0, 33'hc,   0, 0);
    add(0, 2, 1, 1, 0, 0,  0, 33'hc,   0, 0);
    add(0, 2, 1, 1, 0, 0,  0, 33'hc,   0, 0);
    add(0, 2, 1, 1, 0, 0,  0, 33'hc,   0, 0);
    add(0, 2, 0, 1, 0, 0,  1, 33'hc,   1, 33'h0);
    add(0, 2, 0, 1, 0, 0,  1, 33'h10,  1, 33'h4);
    add(0, 2, 0, 1, 0, 0,  1, 33'h14,  1, 33'h8);
    add(0, 2, 0, 1, 0, 0,  1, 33'h18,  1, 33'hc);
    // Redirect to the top of the PC space: address wraps to zero.
    add(1, 1, 0, 1, 1, 33'h1_ffff_fffc, 0, 33'h0,           0, 0);
    add(0, 1, 0, 1, 0, 0,               1, 33'h1_ffff_fffc, 0, 0);
    add(0, 1, 0, 1, 0, 0,               1, 33'h0,           0, 0);
    add(0, 1, 0, 1, 0, 0,               1, 33'h4,           1, 33'h1_ffff_fffc);
    add(0, 1, 0, 1, 0, 0,               1, 33'h8,           1, 33'h0);

    foreach (rows[i]) begin
      if (rows[i].rst) do_reset(rows[i].lat);
      hold           = rows[i].hold;
      out_ready      = rows[i].ordy;
      redirect_valid = rows[i].redir;
      redirect_pc    = rows[i].rpc;
      #1;
      chk($sformatf("row%0d req_valid", i), 33'(imem_req_valid), 33'(rows[i].erv));
      chk($sformatf("row%0d imem_addr", i), imem_addr, rows[i].eaddr);
      chk($sformatf("row%0d out_valid", i), 33'(out_valid), 33'(rows[i].eov));
      if (rows[i].eov) begin
        chk($sformatf("row%0d out_pc", i), out_pc, rows[i].epc);
        chk($sformatf("row%0d out_instruction", i), out_instruction, ~rows[i].epc);
      end
      @(negedge clk);
    end

    // Backpressure: with decode stalled exactly DEPTH requests are accepted.
    do_reset(1);
    out_ready = 1'b0;
    accepted  = 0;
    repeat (10) begin
      #1;
      if (imem_req_valid && imem_req_ready) accepted++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp accepted", 33'(accepted), 33'd4);
    chk("bp req_valid full", 33'(imem_req_valid), 33'd0);
    chk("bp out_valid full", 33'(out_valid), 33'd1);
    chk("bp out_pc head", out_pc, 33'h0);
    @(negedge clk);
    #1;
    chk("bp req_valid resume", 33'(imem_req_valid), 33'd1);
    chk("bp addr resume", imem_addr, 33'h10);
    chk("bp out_pc next", out_pc, 33'h4);

    // Asynchronous reset in the middle of a stream clears outputs at once.
    do_reset(1);
    repeat (4) @(negedge clk);
    #1;
    chk("arst pre out_pc", out_pc, 33'h8);
    chk("arst pre addr", imem_addr, 33'h10);
    reset = 1'b0;
    #1;
    chk("arst req_valid", 33'(imem_req_valid), 33'd0);
    chk("arst imem_addr", imem_addr, 33'h0);
    chk("arst out_valid", 33'(out_valid), 33'd0);
    chk("arst out_pc", out_pc, 33'h0);
    chk("arst out_instruction", out_instruction, 33'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst release req_valid", 33'(imem_req_valid), 33'd1);
    chk("arst release addr", imem_addr, 33'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
